simd_decode_sequencer: RTL
==========================

// Module: simd_decode_sequencer
// PURPOSE
//  Registered successor of the combinational control decoder, placed between fetch and execute.
//  Decodes one instruction per handshake into a registered control bundle.
//  Cracks vector ops into VLANES/LANE_GRP beats with a lane-group index so a narrow SIMD datapath processes the AES state.
//  Scalar ops issue in one beat.
// PARAMETERS
//  OPW      5   opcode width; opcode occupies bits [OPW-1:0], table below uses the low 5 bits
//  ALUCW    3   ALUControl width
//  VLANES   16  byte lanes in a vector register; must be a multiple of LANE_GRP
//  LANE_GRP 4   lanes processed per beat; NBEATS=VLANES/LANE_GRP, IDXW=max(1,$clog2(NBEATS))
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      instruction present
//  in_ready     out  1      sequencer accepts instruction this cycle
//  opcode       in   OPW    instruction opcode
//  flush        in   1      synchronous kill of the in-flight instruction (branch taken)
//  out_valid    out  1      control bundle valid
//  out_ready    in   1      execute consumes bundle this cycle
//  ALUControl   out  ALUCW  ALU operation
//  RegWrite     out  1      scalar register write
//  VRegWrite    out  1      vector register write (current lane group)
//  MemWrite     out  1      memory write
//  Branch       out  1      branch
//  MemToReg     out  2      writeback select: 00 ALU, 01 memory, 10 sbox
//  ALUScr       out  1      1 = immediate operand
//  beat_idx     out  IDXW   lane group of current beat; 0 for scalar
//  last_beat    out  1      final beat of current instruction
//  illegal_err  out  1      sticky illegal-opcode flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; out_valid=0, every control output=0, beat_idx=0, last_beat=0, illegal_err=0.
//  Decode table (ALUC,RW,VW,MW,BR,M2R,SRC):
//   11000 mov imm 000,1,0,0,0,00,1 | 10101 add 000,1,0,0,0,00,0 | 11011 mov rs 000,1,0,0,0,00,0
//   01100 xor 011,1,0,0,0,00,0 | 10001 vadd 000,0,1,0,0,00,0 | 10010 vmov imm 000,0,1,0,0,00,1
//   11100 vxor 011,0,1,0,0,00,0 | 10110 vldr 000,0,1,0,0,01,0 | 10111 vstr 000,0,0,1,0,00,1
//   11010 str 000,0,0,1,0,00,1 | 10100 beq 000,0,0,0,1,00,0 | 11001 b 000,0,0,0,1,00,0
//   11110 sbox 000,0,1,0,0,10,1 | 11111 subst 101,0,1,0,0,00,1 | other: all zero (NOP)
//  Vector class (multi-beat): 10001,10010,11100,10110,10111,11110,11111. All others single beat.
//  States: IDLE (out_valid=0), ISSUE (out_valid=1).
//  in_ready = (state==IDLE) | (out_valid & out_ready & last_beat); accepted opcode registered, 1-cycle latency to out_valid.
//  ISSUE: bundle held stable while out_valid & !out_ready. On out_ready: if last_beat -> load next accepted instr or IDLE;
//   else beat_idx+1, last_beat=(beat_idx+1==NBEATS-1). Controls constant across beats of one instruction.
//  NBEATS=1: vector ops behave as single-beat, last_beat=1, beat_idx=0.
//  flush: priority over everything except reset; next cycle state IDLE, out_valid=0, beat_idx=0, in_ready forced 0 during flush cycle.
//  Back-to-back: last beat consumed and new in_valid same cycle -> new bundle next cycle, no bubble.
//  Async reset mid-sequence: immediate return to reset values; partial vector op discarded.
// CONFIGURATION
//  DECODE_ILLEGAL_TRAP_EN defined: opcode outside table is accepted but dropped (no out_valid), illegal_err set 1 and held until reset.
//  Not defined: such opcode issues one NOP beat (all controls 0, last_beat=1); illegal_err tied 0.
// TESTING
//  Reset: rst_n=0 mid vxor beat 2 -> all outputs 0 immediately; after release in_ready=1, out_valid=0.
//  add 10101, out_ready=1 -> next cycle out_valid=1, RegWrite=1, ALUControl=000, last_beat=1, beat_idx=0; then IDLE.
//  vxor 11100, defaults, out_ready=1 -> 4 beats, beat_idx 0,1,2,3, ALUControl=011, VRegWrite=1, last_beat only on beat 3.
//  vldr with out_ready low 3 cycles on beat 1 -> beat_idx stays 1, M2R=01 stable, in_ready=0; resumes at release.
//  sbox then add back-to-back, out_ready=1 -> 4 sbox beats (M2R=10) immediately followed by add beat, no idle cycle.
//  flush during vadd beat 1 -> next cycle out_valid=0; opcode 00000 -> NOP beat (no macro) or illegal_err=1, no out_valid (macro).

Source files
------------

// File: rtl/simd_decode_sequencer_if.sv
// rtl/simd_decode_sequencer_if.sv - fetch/execute handshake bundle for simd_decode_sequencer
//
// Purpose: groups the instruction-in handshake, the flush input, and the
// registered control bundle out of the decode sequencer.
// Modports:
//   master - environment side: drives in_valid/opcode/flush/out_ready,
//            observes in_ready and the control bundle
//   slave  - sequencer side: the mirror image of master
// Signals:
//   in_valid, in_ready, opcode[OPW]    instruction handshake
//   flush                              kill in-flight instruction
//   out_valid, out_ready               control bundle handshake
//   ALUControl[ALUCW], RegWrite, VRegWrite, MemWrite, Branch,
//   MemToReg[2], ALUScr                decoded controls
//   beat_idx[IDXW], last_beat          lane-group sequencing
//   illegal_err                        sticky illegal-opcode flag
interface simd_decode_sequencer_if #(
    parameter int OPW      = 5,
    parameter int ALUCW    = 3,
    parameter int VLANES   = 16,
    parameter int LANE_GRP = 4
);
    localparam int NBEATS = VLANES / LANE_GRP;
    localparam int IDXW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   opcode;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ALUCW-1:0] ALUControl;
    logic             RegWrite;
    logic             VRegWrite;
    logic             MemWrite;
    logic             Branch;
    logic [1:0]       MemToReg;
    logic             ALUScr;
    logic [IDXW-1:0]  beat_idx;
    logic             last_beat;
    logic             illegal_err;

    modport master (
        output in_valid, opcode, flush, out_ready,
        input  in_ready, out_valid, ALUControl, RegWrite, VRegWrite, MemWrite,
               Branch, MemToReg, ALUScr, beat_idx, last_beat, illegal_err
    );

    modport slave (
        input  in_valid, opcode, flush, out_ready,
        output in_ready, out_valid, ALUControl, RegWrite, VRegWrite, MemWrite,
               Branch, MemToReg, ALUScr, beat_idx, last_beat, illegal_err
    );
endinterface

// File: rtl/simd_decode_sequencer.sv
// rtl/simd_decode_sequencer.sv - registered decode stage cracking vector ops into lane-group beats
//
// Purpose: accepts one opcode per in_valid/in_ready handshake, decodes it into
// a registered control bundle, and issues it for one beat (scalar ops) or
// NBEATS = VLANES/LANE_GRP beats (vector ops), stepping beat_idx per beat.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - simd_decode_sequencer_if.slave: instruction handshake, flush,
//            control bundle, beat_idx/last_beat, illegal_err
// Optional feature: macro DECODE_ILLEGAL_TRAP_EN. When defined, an opcode
// outside the decode table is accepted but dropped and sets the sticky
// illegal_err flag. When undefined, such an opcode issues one all-zero NOP
// beat and illegal_err stays 0.
module simd_decode_sequencer #(
    parameter int OPW      = 5,
    parameter int ALUCW    = 3,
    parameter int VLANES   = 16,
    parameter int LANE_GRP = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    simd_decode_sequencer_if.slave  bus
);
    localparam int NBEATS = VLANES / LANE_GRP;
    localparam int IDXW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBEATS - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic [ALUCW-1:0] alu;
        logic             rw;
        logic             vw;
        logic             mw;
        logic             br;
        logic [1:0]       m2r;
        logic             src;
    } ctrl_t;

    state_t          state, state_n;
    ctrl_t           ctrl_q, ctrl_n;
    logic [IDXW-1:0] beat_q, beat_n;
    logic            last_q, last_n;
    logic            err_q, err_n;

    ctrl_t           dec;
    logic            dec_vec;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic            dec_legal;
`endif
    logic            in_ready_c;
    logic            accept;
    logic            consume;
    logic [IDXW-1:0] beat_inc;

    // Opcode decode; only the low 5 opcode bits select a table entry.
    always_comb begin
        dec     = '0;
        dec_vec = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec_legal = 1'b1;
`endif
        case (bus.opcode[4:0])
            5'b11000: begin dec.rw = 1'b1; dec.src = 1'b1; end
            5'b10101: dec.rw = 1'b1;
            5'b11011: dec.rw = 1'b1;
            5'b01100: begin dec.alu = ALUCW'(3'b011); dec.rw = 1'b1; end
            5'b10001: begin dec.vw = 1'b1; dec_vec = 1'b1; end
            5'b10010: begin dec.vw = 1'b1; dec.src = 1'b1; dec_vec = 1'b1; end
            5'b11100: begin dec.alu = ALUCW'(3'b011); dec.vw = 1'b1; dec_vec = 1'b1; end
            5'b10110: begin dec.vw = 1'b1; dec.m2r = 2'b01; dec_vec = 1'b1; end
            5'b10111: begin dec.mw = 1'b1; dec.src = 1'b1; dec_vec = 1'b1; end
            5'b11010: begin dec.mw = 1'b1; dec.src = 1'b1; end
            5'b10100: dec.br = 1'b1;
            5'b11001: dec.br = 1'b1;
            5'b11110: begin dec.vw = 1'b1; dec.m2r = 2'b10; dec.src = 1'b1; dec_vec = 1'b1; end
            5'b11111: begin dec.alu = ALUCW'(3'b101); dec.vw = 1'b1; dec.src = 1'b1; dec_vec = 1'b1; end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                dec_legal = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ctrl_q <= '0;
            beat_q <= '0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            ctrl_q <= ctrl_n;
            beat_q <= beat_n;
            last_q <= last_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        consume    = (state == ISSUE) && bus.out_ready;
        // A new instruction may enter only when nothing is held, or the final
        // beat leaves this cycle; flush blocks acceptance outright.
        in_ready_c = !bus.flush && ((state == IDLE) || (consume && last_q));
        accept     = in_ready_c && bus.in_valid;
        beat_inc   = beat_q + IDXW'(1);

        state_n = state;
        ctrl_n  = ctrl_q;
        beat_n  = beat_q;
        last_n  = last_q;
        err_n   = err_q;

        if (bus.flush) begin
            state_n = IDLE;
            ctrl_n  = '0;
            beat_n  = '0;
            last_n  = 1'b0;
        end else if (consume && !last_q) begin
            beat_n = beat_inc;
            last_n = (beat_inc == LAST_IDX);
        end else if (accept) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (!dec_legal) begin
                state_n = IDLE;
                ctrl_n  = '0;
                beat_n  = '0;
                last_n  = 1'b0;
                err_n   = 1'b1;
            end else begin
                state_n = ISSUE;
                ctrl_n  = dec;
                beat_n  = '0;
                last_n  = !dec_vec || (NBEATS == 1);
            end
`else
            state_n = ISSUE;
            ctrl_n  = dec;
            beat_n  = '0;
            last_n  = !dec_vec || (NBEATS == 1);
`endif
        end else if (consume) begin
            // Last beat leaves with nothing behind it.
            state_n = IDLE;
            ctrl_n  = '0;
            beat_n  = '0;
            last_n  = 1'b0;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = (state == ISSUE);
    assign bus.ALUControl  = ctrl_q.alu;
    assign bus.RegWrite    = ctrl_q.rw;
    assign bus.VRegWrite   = ctrl_q.vw;
    assign bus.MemWrite    = ctrl_q.mw;
    assign bus.Branch      = ctrl_q.br;
    assign bus.MemToReg    = ctrl_q.m2r;
    assign bus.ALUScr      = ctrl_q.src;
    assign bus.beat_idx    = beat_q;
    assign bus.last_beat   = last_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign bus.illegal_err = err_q;
`else
    assign bus.illegal_err = 1'b0;
`endif

endmodule
